// File: rtl/heap_sort_loader.sv
// heap_sort_loader
// Collects a stream of element_size-bit words into a packed array_size-slot
// frame for heap_sort, pads unused slots so they sort to the tail, asserts
// start, and holds the frame until the consumer acknowledges it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready element handshake (in_ready is registered)
//   in_data, in_last  element and end-of-frame marker
//   flush             close the frame without an element
//   array_o           packed frame, slot k at [k*element_size +: element_size]
//   start             heap_sort start (SETTLE and HOLD)
//   frame_valid       sorted result stable (HOLD)
//   frame_ack         consumer done with frame (honoured in HOLD only)
//   count             number of real elements in the frame
//   overflow          frame exceeded array_size, excess dropped
`timescale 1ns/100ps
module heap_sort_loader #(
    parameter int element_size  = 9,
    parameter int array_size    = 256,
    parameter int MIN_MAX       = 1,
    parameter int SETTLE_CYCLES = 2,
    localparam int CW = $clog2(array_size + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [element_size-1:0]            in_data,
    input  logic                               in_last,
    input  logic                               flush,
    output logic [element_size*array_size-1:0] array_o,
    output logic                               start,
    output logic                               frame_valid,
    input  logic                               frame_ack,
    output logic [CW-1:0]                      count,
    output logic                               overflow
);

    localparam logic [element_size-1:0] PAD =
        (MIN_MAX != 0) ? {element_size{1'b1}} : {element_size{1'b0}};
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_M1     = CW'(array_size - 1);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_SETTLE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              wr_en;
    logic              clear;
    logic              accept;
    logic              flush_ok;

    assign accept   = in_valid && in_ready_q;
    // Flush is only meaningful while the loader is open for input; this keeps
    // the reset-release cycle (FILL with in_ready low) from closing a frame.
    assign flush_ok = flush && in_ready_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            in_ready_q <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            settle_q   <= settle_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        settle_d   = settle_q;
        wr_en      = 1'b0;
        clear      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (in_last || flush) begin
                        state_d = S_SETTLE;
                    end else if (count_q == FULL_M1) begin
                        state_d    = S_DRAIN;
                        overflow_d = 1'b1;
                    end
                end else if (flush_ok) begin
                    state_d = S_SETTLE;
                end
            end
            S_DRAIN: begin
                // Elements are consumed but dropped until the frame closes.
                if ((accept && in_last) || flush_ok) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_HOLD;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    state_d    = S_FILL;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    clear      = 1'b1;
                end
            end
            default: state_d = S_FILL;
        endcase
        in_ready_d = (state_d == S_FILL) || (state_d == S_DRAIN);
    end

    // Output logic
    always_comb begin
        start       = (state_q == S_SETTLE) || (state_q == S_HOLD);
        frame_valid = (state_q == S_HOLD);
    end

    assign in_ready = in_ready_q;
    assign count    = count_q;
    assign overflow = overflow_q;

    // Frame storage: every slot must return to PAD in one cycle on ack, so
    // each slot is its own register rather than a RAM word.
    generate
        for (genvar gi = 0; gi < array_size; gi++) begin : g_slot
            logic [element_size-1:0] slot_q, slot_d;

            always_comb begin
                slot_d = slot_q;
                if (clear) begin
                    slot_d = PAD;
                end else if (wr_en && (count_q == CW'(gi))) begin
                    slot_d = in_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= PAD;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign array_o[gi*element_size +: element_size] = slot_q;
        end
    endgenerate

endmodule
